// File: rtl/gear_selector_if.sv
// rtl/gear_selector_if.sv - driver-side inputs and selector outputs of gear_selector
interface gear_selector_if;
    logic       engine_on;
    logic       brake;
    logic [7:0] speed;
    logic [2:0] gear_num;
    logic       btn_up;
    logic       btn_down;
    logic       btn_low;
    logic       btn_plus;
    logic       btn_minus;
    logic [3:0] current_gear;
    logic       is_low_gear_mode;
    logic [2:0] max_gear_limit;
    logic       shift_ack;
    logic       shift_reject;

    modport master (
        output engine_on, brake, speed, gear_num,
        output btn_up, btn_down, btn_low, btn_plus, btn_minus,
        input  current_gear, is_low_gear_mode, max_gear_limit, shift_ack, shift_reject
    );

    modport slave (
        input  engine_on, brake, speed, gear_num,
        input  btn_up, btn_down, btn_low, btn_plus, btn_minus,
        output current_gear, is_low_gear_mode, max_gear_limit, shift_ack, shift_reject
    );
endinterface

// File: rtl/gear_selector.sv
// rtl/gear_selector.sv - debounced P/R/N/D selector with brake/speed interlocks and manual low-gear limit
// Optional AUTO_PARK_EN: engine-off at standstill forces P.
module gear_selector #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int R_ENTRY_MAX_SPEED = 3,
    parameter int LOW_DOWN_GUARD    = 30
) (
    input  logic            clk,
    input  logic            rst,
    gear_selector_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_P = 4'd3,
        S_R = 4'd6,
        S_N = 4'd9,
        S_D = 4'd12
    } gear_t;

    // Button bit order: up, down, low, plus, minus
    logic [4:0]    raw;
    logic [4:0]    sync1, sync2, db_level, db_prev, req;
    logic [CW-1:0] cnt [5];

    assign raw = {bus.btn_up, bus.btn_down, bus.btn_low, bus.btn_plus, bus.btn_minus};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            req      <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db_level;
            req     <= db_level & ~db_prev;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    logic       req_up, req_dn, req_low, req_plus, req_minus;
    gear_t      state;
    logic       low_mode;
    logic [2:0] lim;
    logic       ack, rej;
    logic [2:0] gear_clamped;
    logic [8:0] down_guard;
    logic       minus_ok;

    assign {req_up, req_dn, req_low, req_plus, req_minus} = req;

    always_comb begin
        gear_clamped = bus.gear_num;
        if (bus.gear_num == 3'd0) gear_clamped = 3'd1;
        if (bus.gear_num == 3'd7) gear_clamped = 3'd6;
    end

    // Speed ceiling for stepping down to target lim-1; only meaningful when lim>1.
    assign down_guard = 9'd5 + 9'd30 * ({6'd0, lim} - 9'd2) + 9'(LOW_DOWN_GUARD);
    assign minus_ok   = (lim > 3'd1) && ({1'b0, bus.speed} <= down_guard);

`ifdef AUTO_PARK_EN
    logic engine_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_P;
            low_mode <= 1'b0;
            lim      <= 3'd6;
            ack      <= 1'b0;
            rej      <= 1'b0;
`ifdef AUTO_PARK_EN
            engine_q <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
            rej <= 1'b0;
`ifdef AUTO_PARK_EN
            engine_q <= bus.engine_on;
            if (engine_q && !bus.engine_on && bus.speed == 8'd0) begin
                state    <= S_P;
                low_mode <= 1'b0;
                lim      <= 3'd6;
                ack      <= 1'b1;
            end else
`endif
            if (req_up || req_dn) begin
                // Selector wins; any concurrent low/plus/minus request is dropped.
                if ((req_up && req_dn) || !bus.engine_on) begin
                    rej <= 1'b1;
                end else if (req_up) begin
                    case (state)
                        S_R: if (bus.speed == 8'd0) begin
                                 state <= S_P;
                                 ack   <= 1'b1;
                             end else rej <= 1'b1;
                        S_N: if (bus.speed <= 8'(R_ENTRY_MAX_SPEED)) begin
                                 state <= S_R;
                                 ack   <= 1'b1;
                             end else rej <= 1'b1;
                        S_D: begin
                                 state    <= S_N;
                                 low_mode <= 1'b0;
                                 lim      <= 3'd6;
                                 ack      <= 1'b1;
                             end
                        default: rej <= 1'b1;
                    endcase
                end else begin
                    case (state)
                        S_P: if (bus.brake && bus.speed == 8'd0) begin
                                 state <= S_R;
                                 ack   <= 1'b1;
                             end else rej <= 1'b1;
                        S_R: begin
                                 state <= S_N;
                                 ack   <= 1'b1;
                             end
                        S_N: begin
                                 state <= S_D;
                                 ack   <= 1'b1;
                             end
                        default: rej <= 1'b1;
                    endcase
                end
            end else if (req_low || req_plus || req_minus) begin
                if (!bus.engine_on || (req_plus && req_minus)) begin
                    rej <= 1'b1;
                end else if (req_low) begin
                    if (state != S_D) begin
                        rej <= 1'b1;
                    end else if (low_mode) begin
                        low_mode <= 1'b0;
                        lim      <= 3'd6;
                        ack      <= 1'b1;
                    end else begin
                        low_mode <= 1'b1;
                        lim      <= gear_clamped;
                        ack      <= 1'b1;
                    end
                end else if (req_plus) begin
                    if (low_mode && lim != 3'd6) begin
                        lim <= lim + 3'd1;
                        ack <= 1'b1;
                    end else rej <= 1'b1;
                end else begin
                    if (low_mode && minus_ok) begin
                        lim <= lim - 3'd1;
                        ack <= 1'b1;
                    end else rej <= 1'b1;
                end
            end
        end
    end

    assign bus.current_gear     = state;
    assign bus.is_low_gear_mode = low_mode;
    assign bus.max_gear_limit   = lim;
    assign bus.shift_ack        = ack;
    assign bus.shift_reject     = rej;
endmodule

// File: tb/tb_gear_selector.sv
// tb/tb_gear_selector.sv - scoreboard bench for gear_selector
module tb_gear_selector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gear_selector_if bus ();
    gear_selector dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [4:0] UP = 5'b10000;
    localparam logic [4:0] DN = 5'b01000;
    localparam logic [4:0] LO = 5'b00100;
    localparam logic [4:0] PL = 5'b00010;
    localparam logic [4:0] MI = 5'b00001;

`ifdef AUTO_PARK_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    typedef struct packed {
        logic       ack;
        logic [3:0] gear;
        logic       mode;
        logic [2:0] lim;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   pulse_cnt = 0;
    int   last_lat;
    int   p0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b);
        {bus.btn_up, bus.btn_down, bus.btn_low, bus.btn_plus, bus.btn_minus} = b;
    endtask

    task automatic push(input logic ack, input int gear, input int mode, input int lim);
        exp_t e;
        e.ack  = ack;
        e.gear = 4'(gear);
        e.mode = 1'(mode);
        e.lim  = 3'(lim);
        sb.push_back(e);
    endtask

    task automatic press(input logic [4:0] b, input logic ack, input int gear, input int mode, input int lim);
        push(ack, gear, mode, lim);
        last_lat = -1;
        drive(b);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((bus.shift_ack || bus.shift_reject) && last_lat < 0) last_lat = i - 1;
        end
        drive(5'b0);
        repeat (10) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.shift_ack || bus.shift_reject)) begin
            pulse_cnt++;
            check("ack_rej_excl", int'(bus.shift_ack & bus.shift_reject), 0);
            check("sb_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sb_ack", bus.shift_ack, mon_e.ack);
                check("sb_gear", bus.current_gear, mon_e.gear);
                check("sb_mode", bus.is_low_gear_mode, mon_e.mode);
                check("sb_lim", bus.max_gear_limit, mon_e.lim);
            end
        end
    end

    initial begin
        bus.engine_on = 1'b0;
        bus.brake     = 1'b0;
        bus.speed     = 8'd0;
        bus.gear_num  = 3'd1;
        drive(5'b0);
        repeat (3) @(negedge clk);
        check("rst_gear", bus.current_gear, 3);
        check("rst_mode", bus.is_low_gear_mode, 0);
        check("rst_lim", bus.max_gear_limit, 6);
        check("rst_ack", bus.shift_ack, 0);
        check("rst_rej", bus.shift_reject, 0);
        rst = 1'b0;
        bus.engine_on = 1'b1;
        repeat (2) @(negedge clk);

        // P interlocks and the end stop
        press(DN, 1'b0, 3, 0, 6);
        check("latency", last_lat, 7);
        press(UP, 1'b0, 3, 0, 6);
        bus.brake = 1'b1;
        press(DN, 1'b1, 6, 0, 6);
        press(DN, 1'b1, 9, 0, 6);
        bus.brake = 1'b0;

        // N->R speed boundary
        bus.speed = 8'd10;
        press(UP, 1'b0, 9, 0, 6);
        bus.speed = 8'd3;
        press(UP, 1'b1, 6, 0, 6);
        press(DN, 1'b1, 9, 0, 6);
        bus.speed = 8'd0;
        press(DN, 1'b1, 12, 0, 6);
        press(DN, 1'b0, 12, 0, 6);

        // Low-gear entry and limit stepping
        bus.gear_num = 3'd4;
        press(LO, 1'b1, 12, 1, 4);
        bus.speed = 8'd100;
        press(MI, 1'b0, 12, 1, 4);
        bus.speed = 8'd90;
        press(MI, 1'b1, 12, 1, 3);
        press(PL, 1'b1, 12, 1, 4);
        press(PL, 1'b1, 12, 1, 5);
        press(PL, 1'b1, 12, 1, 6);
        press(PL, 1'b0, 12, 1, 6);

        // Downshift guard edges at 35 km/h
        bus.speed = 8'd35;
        for (int l = 5; l >= 1; l--) press(MI, 1'b1, 12, 1, l);
        press(MI, 1'b0, 12, 1, 1);
        press(PL, 1'b1, 12, 1, 2);
        bus.speed = 8'd36;
        press(MI, 1'b0, 12, 1, 2);

        // Toggle off, mode-off plus, gear_num clamping
        press(LO, 1'b1, 12, 0, 6);
        press(PL, 1'b0, 12, 0, 6);
        bus.gear_num = 3'd7;
        press(LO, 1'b1, 12, 1, 6);
        press(LO, 1'b1, 12, 0, 6);
        bus.gear_num = 3'd0;
        press(LO, 1'b1, 12, 1, 1);
        press(LO, 1'b1, 12, 0, 6);
        bus.gear_num = 3'd2;
        press(LO, 1'b1, 12, 1, 2);
        press(UP, 1'b1, 9, 0, 6);

        // Glitchy button never reaches a request
        p0 = pulse_cnt;
        drive(UP); repeat (3) @(negedge clk);
        drive(5'b0); repeat (1) @(negedge clk);
        drive(UP); repeat (3) @(negedge clk);
        drive(5'b0); repeat (15) @(negedge clk);
        check("glitch_pulses", pulse_cnt - p0, 0);
        check("glitch_gear", bus.current_gear, 9);

        // Simultaneous requests
        p0 = pulse_cnt;
        press(UP | DN, 1'b0, 9, 0, 6);
        check("updown_one_pulse", pulse_cnt - p0, 1);
        press(PL | MI, 1'b0, 9, 0, 6);
        press(LO, 1'b0, 9, 0, 6);
        p0 = pulse_cnt;
        press(DN | LO, 1'b1, 12, 0, 6);
        check("sel_wins_one_pulse", pulse_cnt - p0, 1);

        // Engine off at standstill in D
        bus.speed = 8'd0;
        if (AP) push(1'b1, 3, 0, 6);
        bus.engine_on = 1'b0;
        repeat (5) @(negedge clk);
        check("engine_off_gear", bus.current_gear, AP ? 3 : 12);
        check("engine_off_drain", sb.size(), 0);
        sb.delete();
        press(DN, 1'b0, AP ? 3 : 12, 0, 6);

        // Engine off while moving in D
        bus.engine_on = 1'b1;
        repeat (2) @(negedge clk);
        if (AP) begin
            bus.brake = 1'b1;
            press(DN, 1'b1, 6, 0, 6);
            press(DN, 1'b1, 9, 0, 6);
            press(DN, 1'b1, 12, 0, 6);
            bus.brake = 1'b0;
        end
        bus.speed = 8'd20;
        p0 = pulse_cnt;
        bus.engine_on = 1'b0;
        repeat (5) @(negedge clk);
        check("moving_off_gear", bus.current_gear, 12);
        check("moving_off_pulses", pulse_cnt - p0, 0);

        // Reset in the middle of a debounce discards the request
        bus.engine_on = 1'b1;
        bus.speed = 8'd0;
        bus.brake = 1'b1;
        repeat (2) @(negedge clk);
        drive(DN);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        drive(5'b0);
        rst = 1'b0;
        p0 = pulse_cnt;
        repeat (15) @(negedge clk);
        check("rst_mid_pulses", pulse_cnt - p0, 0);
        check("rst_mid_gear", bus.current_gear, 3);
        check("rst_mid_lim", bus.max_gear_limit, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
